// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for an in-order pipeline.
// Tracks every post-decode pipeline register in a small scoreboard and drives
// per-register PAUSE/FLUSH/NORMAL controls, operand-forwarding selects and
// stall/flush performance counters. All state updates on the falling clock edge.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int BR_STAGE   = 2,
  parameter int LOAD_STAGE = 3,
  parameter int AW         = 5
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      id_valid,
  input  logic [AW-1:0]             id_rs1,
  input  logic [AW-1:0]             id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [AW-1:0]             id_rd,
  input  logic                      id_regwr,
  input  logic                      id_is_load,
  input  logic                      branch_taken,
  input  logic                      mem_busy,
  output logic [2*(NSTAGE+2)-1:0]   pl_ctrl,
  output logic [2:0]                fwd_rs1_sel,
  output logic [2:0]                fwd_rs2_sel,
  output logic                      stall,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  localparam logic [1:0] PL_NORMAL = 2'b00;
  localparam logic [1:0] PL_PAUSE  = 2'b01;
  localparam logic [1:0] PL_FLUSH  = 2'b10;

  // One shadow entry per datapath register after decode.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwr;
    logic          is_load;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
  } sb_t;

  sb_t         sb_q [1:NSTAGE];
  sb_t         sb_d [1:NSTAGE];
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  // Load-use hazard: a load still too young to forward feeds a source of the ID instruction.
  always_comb begin
    load_use = 1'b0;
    for (int k = 1; k <= NSTAGE; k++) begin
      if (k <= LOAD_STAGE - 2) begin
        if (sb_q[k].valid && sb_q[k].is_load && sb_q[k].regwr && (sb_q[k].rd != '0) &&
            ((id_use_rs1 && (sb_q[k].rd == id_rs1)) ||
             (id_use_rs2 && (sb_q[k].rd == id_rs2)))) begin
          load_use = 1'b1;
        end
      end
    end
    load_use = load_use & id_valid;
  end

  // Register controls and stall flag; mem_busy outranks branch, branch outranks load-use.
  always_comb begin
    pl_ctrl = '0;
    stall   = 1'b0;
    for (int i = 0; i < NSTAGE + 2; i++) begin
      if (!clr) begin
        pl_ctrl[2*i +: 2] = PL_FLUSH;
      end else if (mem_busy) begin
        pl_ctrl[2*i +: 2] = PL_PAUSE;
      end else if (branch_taken) begin
        // Field 0 (PC) loads the target; IF/ID and entries 1..BR_STAGE are squashed.
        pl_ctrl[2*i +: 2] = ((i >= 1) && (i <= BR_STAGE + 1)) ? PL_FLUSH : PL_NORMAL;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject a bubble into entry 1.
        if (i <= 1) begin
          pl_ctrl[2*i +: 2] = PL_PAUSE;
        end else if (i == 2) begin
          pl_ctrl[2*i +: 2] = PL_FLUSH;
        end else begin
          pl_ctrl[2*i +: 2] = PL_NORMAL;
        end
      end else begin
        pl_ctrl[2*i +: 2] = PL_NORMAL;
      end
    end
    if (clr && !mem_busy && !branch_taken && load_use) begin
      stall = 1'b1;
    end
  end

  // Next scoreboard contents and counter values.
  always_comb begin
    for (int k = 1; k <= NSTAGE; k++) begin
      sb_d[k] = sb_q[k];
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_busy) begin
      for (int k = NSTAGE; k >= 2; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[1].valid   = id_valid;
      sb_d[1].rd      = id_rd;
      sb_d[1].regwr   = id_regwr;
      sb_d[1].is_load = id_is_load;
      sb_d[1].rs1     = id_rs1;
      sb_d[1].rs2     = id_rs2;
      sb_d[1].use_rs1 = id_use_rs1;
      sb_d[1].use_rs2 = id_use_rs2;
      if (branch_taken) begin
        // The branch itself moves up to BR_STAGE+1 (or retires when BR_STAGE == NSTAGE).
        for (int k = 1; k <= NSTAGE; k++) begin
          if (k <= BR_STAGE) begin
            sb_d[k].valid = 1'b0;
          end
        end
        flush_cnt_d = flush_cnt_q + 32'(BR_STAGE);
      end else if (load_use) begin
        sb_d[1].valid = 1'b0;
        stall_cnt_d   = stall_cnt_q + 32'd1;
      end
    end
  end

  // Scoreboard and counter registers, cleared asynchronously.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 1; k <= NSTAGE; k++) begin
        sb_q[k] <= sb_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Forwarding for the instruction in entry 1: youngest matching producer wins.
  always_comb begin
    fwd_rs1_sel = 3'd0;
    fwd_rs2_sel = 3'd0;
    if (clr && sb_q[1].valid) begin
      for (int k = NSTAGE; k >= 2; k--) begin
        if (sb_q[k].valid && sb_q[k].regwr && (sb_q[k].rd != '0)) begin
          if (sb_q[1].use_rs1 && (sb_q[k].rd == sb_q[1].rs1)) begin
            fwd_rs1_sel = 3'(k);
          end
          if (sb_q[1].use_rs2 && (sb_q[k].rd == sb_q[1].rs2)) begin
            fwd_rs2_sel = 3'(k);
          end
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
